// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command decoder and single-port RAM behind an SPI slave.
// Frames carry a 2-bit command plus an ADDR_SIZE-bit payload. Read data is
// presented on tx_data with tx_valid held for TX_HOLD cycles.
//
// state | meaning
// IDLE  | no read in progress, a read-data command may be accepted
// HOLD  | tx_valid high, tx_data frozen while the slave shifts it out
module spi_ram_ctrl #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256,
  parameter int TX_HOLD   = ADDR_SIZE + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE+1:0] rx_data,
  input  logic                 rx_valid,
  output logic [ADDR_SIZE-1:0] tx_data,
  output logic                 tx_valid,
  output logic                 cmd_err
);

  localparam int                   CNT_W     = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;
  localparam logic [CNT_W-1:0]     CNT_LOAD  = CNT_W'(TX_HOLD - 1);
  localparam logic [ADDR_SIZE:0]   DEPTH     = (ADDR_SIZE + 1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;

  logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic                 wr_addr_vld, rd_addr_vld;

  logic [1:0]           cmd;
  logic [ADDR_SIZE-1:0] payload;
  logic                 in_range;
  logic                 wa_ok, wd_ok, ra_ok, rd_ok, err_nxt;

  assign cmd      = rx_data[ADDR_SIZE+1:ADDR_SIZE];
  assign payload  = rx_data[ADDR_SIZE-1:0];
  assign in_range = ({1'b0, payload} < DEPTH);

  // Decode a qualified frame into one accept strobe or an error.
  always_comb begin
    wa_ok   = 1'b0;
    wd_ok   = 1'b0;
    ra_ok   = 1'b0;
    rd_ok   = 1'b0;
    err_nxt = 1'b0;
    if (rx_valid) begin
      case (cmd)
        2'b00: if (in_range) wa_ok = 1'b1; else err_nxt = 1'b1;
        2'b01: if (wr_addr_vld) wd_ok = 1'b1; else err_nxt = 1'b1;
        2'b10: if (in_range) ra_ok = 1'b1; else err_nxt = 1'b1;
        default: if (rd_addr_vld && (state == IDLE)) rd_ok = 1'b1; else err_nxt = 1'b1;
      endcase
    end
  end

  // Address registers: write pointer auto-increments with wrap at MEM_DEPTH,
  // read address is consumed by each accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr     <= '0;
      wr_addr_vld <= 1'b0;
      rd_addr     <= '0;
      rd_addr_vld <= 1'b0;
    end else begin
      if (wa_ok) begin
        wr_addr     <= payload;
        wr_addr_vld <= 1'b1;
      end else if (wd_ok) begin
        wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + 1'b1;
      end
      if (ra_ok) begin
        rd_addr     <= payload;
        rd_addr_vld <= 1'b1;
      end else if (rd_ok) begin
        rd_addr_vld <= 1'b0;
      end
    end
  end

  // RAM array; deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wd_ok) mem[wr_addr] <= payload;
  end

  // Capture read data once per accepted read; later writes cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        tx_data <= '0;
    else if (rd_ok) tx_data <= mem[rd_addr];
  end

  // One-cycle error pulse per rejected frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cmd_err <= 1'b0;
    else     cmd_err <= err_nxt;
  end

  // TX FSM state and hold down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // TX FSM next state: hold for TX_HOLD cycles, leaving on terminal count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (rd_ok) begin
        state_nxt = HOLD;
        cnt_nxt   = CNT_LOAD;
      end
      default: if (cnt == '0) state_nxt = IDLE;
               else           cnt_nxt   = cnt - 1'b1;
    endcase
  end

  assign tx_valid = (state == HOLD);

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl (MEM_DEPTH=200 to exercise range and wrap).
module tb_spi_ram_ctrl;

  localparam int AW    = 8;
  localparam int DEPTH = 200;
  localparam int HOLD  = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW+1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic [AW-1:0] tx_data;
  logic          tx_valid;
  logic          cmd_err;

  int            errors = 0;
  int            checks = 0;
  logic [AW-1:0] exp_q[$];

  spi_ram_ctrl #(.ADDR_SIZE(AW), .MEM_DEPTH(DEPTH), .TX_HOLD(HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one frame for one cycle, then check cmd_err and tx_valid a cycle later.
  task automatic send(input logic [1:0] c, input logic [7:0] p, input logic ee,
                      input logic etv, input string tag);
    @(negedge clk);
    rx_data  = {c, p};
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = '0;
    check({tag, "_err"}, cmd_err, ee);
    check({tag, "_tv"}, tx_valid, etv);
  endtask

  task automatic write_word(input logic [7:0] a, input logic [7:0] d);
    send(2'b00, a, 1'b0, 1'b0, "wa");
    send(2'b01, d, 1'b0, 1'b0, "wd");
  endtask

  task automatic read_word(input logic [7:0] a, input logic [7:0] d);
    send(2'b10, a, 1'b0, 1'b0, "ra");
    exp_q.push_back(d);
    send(2'b11, 8'h00, 1'b0, 1'b1, "rd");
  endtask

  task automatic wait_idle();
    int n = 0;
    while (tx_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("hold_end", tx_valid, 1'b0);
  endtask

  // Monitor: pop expected data on each tx_valid rise, check stability and width.
  logic          prev_tv = 1'b0;
  int            run = 0;
  logic [AW-1:0] held = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_tv = 1'b0;
      run     = 0;
    end else begin
      if (tx_valid && !prev_tv) begin
        if (exp_q.size() == 0) check("tx_unexpected", tx_valid, 1'b0);
        else                   check("rd_data", tx_data, exp_q.pop_front());
        run  = 1;
        held = tx_data;
      end else if (tx_valid) begin
        run++;
        check("tx_stable", tx_data, held);
      end else if (prev_tv) begin
        check("hold_len", run, HOLD);
      end
      prev_tv = tx_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check("rst_tv", tx_valid, 1'b0);
    check("rst_txd", tx_data, 8'h00);
    check("rst_err", cmd_err, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // Data retained across reset; commands without valid addresses rejected.
    write_word(8'h00, 8'h33);
    @(negedge clk); #2 rst = 1'b1;
    #1 check("prst_tv", tx_valid, 1'b0);
    @(negedge clk); #2 rst = 1'b0;
    send(2'b01, 8'h55, 1'b1, 1'b0, "wd_novld");
    send(2'b11, 8'h00, 1'b1, 1'b0, "rd_novld");
    read_word(8'h00, 8'h33);
    wait_idle();

    // Basic write/read.
    write_word(8'h12, 8'hA5);
    read_word(8'h12, 8'hA5);
    wait_idle();

    // Burst write wraps from MEM_DEPTH-1 to 0.
    write_word(8'hC7, 8'h11);
    send(2'b01, 8'h22, 1'b0, 1'b0, "wd_wrap");
    read_word(8'hC7, 8'h11);
    wait_idle();
    read_word(8'h00, 8'h22);
    wait_idle();

    // Out-of-range address leaves wr_addr at 1 (post-wrap).
    send(2'b00, 8'hC8, 1'b1, 1'b0, "wa_range");
    send(2'b01, 8'h66, 1'b0, 1'b0, "wd_after_err");
    send(2'b10, 8'hC8, 1'b1, 1'b0, "ra_range");
    send(2'b11, 8'h00, 1'b1, 1'b0, "rd_after_rerr");
    read_word(8'h01, 8'h66);
    wait_idle();

    // Read address consumed by each read.
    write_word(8'h04, 8'h44);
    read_word(8'h04, 8'h44);
    wait_idle();
    send(2'b11, 8'h00, 1'b1, 1'b0, "rd_again");
    read_word(8'h04, 8'h44);
    wait_idle();

    // Overlap during HOLD.
    write_word(8'h20, 8'h5A);
    read_word(8'h20, 8'h5A);
    send(2'b00, 8'h20, 1'b0, 1'b1, "ov_wa");
    send(2'b01, 8'hBB, 1'b0, 1'b1, "ov_wd");
    send(2'b11, 8'h00, 1'b1, 1'b1, "ov_rd");
    send(2'b10, 8'h20, 1'b0, 1'b1, "ov_ra");
    wait_idle();
    exp_q.push_back(8'hBB);
    send(2'b11, 8'h00, 1'b0, 1'b1, "ov_rd2");
    wait_idle();

    // Reset mid-HOLD.
    read_word(8'h12, 8'hA5);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_tv", tx_valid, 1'b0);
    check("mid_rst_txd", tx_data, 8'h00);
    @(negedge clk); #2 rst = 1'b0;
    send(2'b11, 8'h00, 1'b1, 1'b0, "rd_after_rst");
    read_word(8'h12, 8'hA5);
    wait_idle();

    repeat (2) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
